// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit that holds the architectural
// HI/LO registers.
// Multiply uses shift-add and divide uses restoring shift-subtract. Both run
// DATA_W steps, one bit per clock.
// Optional macro SIGNED_OPS_EN: when defined, op[1] selects signed MULT/DIV.
// Signed operations work on magnitudes, and the results are negated in the
// FIX state.
module mult_div_unit #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] read_data1,
   input  logic [DATA_W-1:0] read_data2,
   input  logic              hi_write,
   input  logic              lo_write,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy,
   output logic              done,
   output logic              div_by_zero
);

   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } state_t;

   state_t              state;
   logic [2*DATA_W-1:0] acc;        // product, or {remainder, quotient}
   logic [DATA_W-1:0]   opnd;       // multiplicand magnitude or divisor magnitude
   logic [DATA_W-1:0]   dividend;   // raw rs, needed for the divide-by-zero result
   logic [CNT_W-1:0]    count;
   logic                is_div;
   logic                div_zero;
   logic                neg_res;    // product / quotient must be negated
   logic                neg_rem;    // remainder must be negated (dividend sign)

   logic                signed_sel;
   logic                a_neg;
   logic                b_neg;
   logic [DATA_W-1:0]   a_mag;
   logic [DATA_W-1:0]   b_mag;

   logic [DATA_W:0]     mul_sum;
   logic [2*DATA_W-1:0] mul_next;
   logic [DATA_W:0]     div_shift;
   logic [DATA_W:0]     div_diff;
   logic [2*DATA_W-1:0] div_next;
   logic [2*DATA_W-1:0] prod_neg;
   logic [DATA_W-1:0]   fix_hi;
   logic [DATA_W-1:0]   fix_lo;

   // Operand sign decode and magnitude conversion at start
   always_comb begin
`ifdef SIGNED_OPS_EN
      signed_sel = op[1];
`else
      // op[1] has no effect in the unsigned-only build
      signed_sel = op[1] & 1'b0;
`endif
      a_neg = signed_sel & read_data1[DATA_W-1];
      b_neg = signed_sel & read_data2[DATA_W-1];
      a_mag = a_neg ? (-read_data1) : read_data1;
      b_mag = b_neg ? (-read_data2) : read_data2;
   end

   // One iteration of shift-add multiply and restoring divide
   always_comb begin
      mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next  = {mul_sum, acc[DATA_W-1:1]};
      div_shift = acc[2*DATA_W-1:DATA_W-1];
      div_diff  = div_shift - {1'b0, opnd};
      // A set top bit of the difference means the trial subtraction borrowed
      div_next  = div_diff[DATA_W] ?
                  {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0} :
                  {div_diff[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};
   end

   // Sign correction and divide-by-zero result applied in FIX
   always_comb begin
      prod_neg = -acc;
      fix_hi   = acc[2*DATA_W-1:DATA_W];
      fix_lo   = acc[DATA_W-1:0];
      if (!is_div) begin
         if (neg_res) begin
            fix_hi = prod_neg[2*DATA_W-1:DATA_W];
            fix_lo = prod_neg[DATA_W-1:0];
         end
      end else if (div_zero) begin
         // Overrides the sign correction, so a signed dividend is returned unchanged
         fix_hi = dividend;
         fix_lo = '1;
      end else begin
         if (neg_res) fix_lo = -acc[DATA_W-1:0];
         if (neg_rem) fix_hi = -acc[2*DATA_W-1:DATA_W];
      end
   end

   // Control FSM, datapath registers and the architectural HI/LO registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         hi          <= '0;
         lo          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         acc         <= '0;
         opnd        <= '0;
         dividend    <= '0;
         count       <= '0;
         is_div      <= 1'b0;
         div_zero    <= 1'b0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div   <= op[0];
                  opnd     <= op[0] ? b_mag : a_mag;
                  acc      <= {{DATA_W{1'b0}}, (op[0] ? a_mag : b_mag)};
                  dividend <= read_data1;
                  div_zero <= op[0] & (read_data2 == '0);
                  neg_res  <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  count    <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end else begin
                  if (hi_write) hi <= write_data;
                  if (lo_write) lo <= write_data;
               end
            end
            RUN: begin
               acc   <= is_div ? div_next : mul_next;
               count <= count + 1'b1;
               if (count == LAST_STEP) state <= FIX;
            end
            FIX: begin
               acc   <= {fix_hi, fix_lo};
               busy  <= 1'b0;
               state <= DONE;
            end
            DONE: begin
               hi          <= acc[2*DATA_W-1:DATA_W];
               lo          <= acc[DATA_W-1:0];
               done        <= 1'b1;
               div_by_zero <= div_zero;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit. A monitor compares
// each done pulse against the oldest queued expectation.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic        hi_write;
   logic        lo_write;
   logic [31:0] write_data;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   e0;

   mult_div_unit #(.DATA_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .read_data1  (read_data1),
      .read_data2  (read_data2),
      .hi_write    (hi_write),
      .lo_write    (lo_write),
      .write_data  (write_data),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expectation
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk32("done_hi", hi, mon_e.hi);
            chk32("done_lo", lo, mon_e.lo);
            chk1("done_div_by_zero", div_by_zero, mon_e.dz);
            chk32("done_latency_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   // Drive one start; optionally queue its expected result, then scramble operands
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic push, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz);
      @(negedge clk);
      start      = 1'b1;
      op         = o;
      read_data1 = a;
      read_data2 = b;
      if (push) sb.push_back('{hi: eh, lo: el, dz: edz, cyc: cyc + 35});
      @(negedge clk);
      start      = 1'b0;
      read_data1 = $urandom;
      read_data2 = $urandom;
      chk1("busy_after_start", busy, 1'b1);
   endtask

   // Wait for the scoreboard to drain; check the busy window on the way
   task automatic wait_done(input int start_cyc);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         #1;
         if (cyc == start_cyc + 32) chk1("busy_last_run_cycle", busy, 1'b1);
         if (cyc == start_cyc + 33) begin
            chk1("busy_low_in_done_state", busy, 1'b0);
            chk1("done_not_early", done, 1'b0);
         end
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=pending_%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz);
      issue(o, a, b, 1'b1, eh, el, edz);
      wait_done(cyc);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      op         = 2'b00;
      read_data1 = '0;
      read_data2 = '0;
      hi_write   = 1'b0;
      lo_write   = 1'b0;
      write_data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk32("reset_hi", hi, 32'h0);
      chk32("reset_lo", lo, 32'h0);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_done", done, 1'b0);
      chk1("reset_div_by_zero", div_by_zero, 1'b0);

      // MTHI then MTLO in IDLE
      hi_write   = 1'b1;
      write_data = 32'h12345678;
      @(negedge clk);
      hi_write = 1'b0;
      chk32("mthi_hi", hi, 32'h12345678);
      chk32("mthi_lo_untouched", lo, 32'h0);
      lo_write   = 1'b1;
      write_data = 32'h9ABCDEF0;
      @(negedge clk);
      lo_write = 1'b0;
      chk32("mtlo_lo", lo, 32'h9ABCDEF0);
      chk32("mtlo_hi_untouched", hi, 32'h12345678);

      // MULTU with a second start and MTHI/MTLO strobes while busy
      issue(2'b00, 32'hFFFFFFFF, 32'h00000002, 1'b1, 32'h00000001, 32'hFFFFFFFE, 1'b0);
      e0 = cyc;
      repeat (3) @(negedge clk);
      start      = 1'b1;
      op         = 2'b01;
      read_data1 = 32'd100;
      read_data2 = 32'd7;
      hi_write   = 1'b1;
      lo_write   = 1'b1;
      write_data = 32'hDEADBEEF;
      @(negedge clk);
      start    = 1'b0;
      hi_write = 1'b0;
      lo_write = 1'b0;
      @(negedge clk);
      chk32("busy_mthi_dropped", hi, 32'h12345678);
      chk32("busy_mtlo_dropped", lo, 32'h9ABCDEF0);
      wait_done(e0);

      // Unsigned divide, including divide by zero
      run_op(2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run_op(2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
      run_op(2'b01, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0);
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0);
      run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);

      // Signed opcodes: results depend on the build
`ifdef SIGNED_OPS_EN
      run_op(2'b10, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      run_op(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      run_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0);
      run_op(2'b11, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
`else
      run_op(2'b10, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 1'b0);
      run_op(2'b11, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 1'b0);
      run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);
      run_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000006, 32'hFFFFFFF2, 1'b0);
      run_op(2'b11, 32'd7, 32'hFFFFFFFE, 32'h00000007, 32'h00000000, 1'b0);
`endif
      run_op(2'b11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);

      // Start and MTHI/MTLO in the same cycle: the strobes are dropped
      @(negedge clk);
      start      = 1'b1;
      op         = 2'b00;
      read_data1 = 32'h00010001;
      read_data2 = 32'h00030000;
      hi_write   = 1'b1;
      lo_write   = 1'b1;
      write_data = 32'hCAFEF00D;
      sb.push_back('{hi: 32'h00000003, lo: 32'h00030000, dz: 1'b0, cyc: cyc + 35});
      @(negedge clk);
      start    = 1'b0;
      hi_write = 1'b0;
      lo_write = 1'b0;
      e0       = cyc;
      chk32("start_priority_hi", hi, 32'hFFFFFFFB);
      chk32("start_priority_lo", lo, 32'hFFFFFFFF);
      wait_done(e0);

      // Reset in the 10th RUN cycle aborts the operation
      issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk32("abort_hi", hi, 32'h0);
      chk32("abort_lo", lo, 32'h0);
      chk1("abort_busy", busy, 1'b0);
      repeat (45) @(negedge clk);
      chk1("abort_busy_stays_low", busy, 1'b0);
      chk32("abort_no_late_hi", hi, 32'h0);

      // Normal operation resumes after the abort
      run_op(2'b00, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 1'b0);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
